// File: rtl/tx_transmitter.sv
// Serial frame transmitter: preamble, SFD, header, payload and CRC-8 driven one bit per clock,
// followed by an idle gap of IFG_BITS zeros before the next request is accepted.
module crc8_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc_out
);
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] base;
    logic       fb;

    // clear acts before the shift, so a bit enabled in the last clear cycle starts from zero
    always_comb begin
        base  = clear ? '0 : crc_q;
        fb    = base[7] ^ data_in;
        crc_d = base;
        if (enable) begin
            crc_d = {base[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;
endmodule

module tx_transmitter #(
    parameter int unsigned IFG_BITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   dest_id,
    input  logic [1:0]   src_id,
    input  logic [3:0]   length,
    input  logic [127:0] payload,
    output logic         tx_line,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_CRC, S_GAP
    } state_t;

    localparam logic [7:0] SFD      = 8'hAB;
    localparam logic [7:0] GAP_LAST = 8'(IFG_BITS - 1);

    // state_q/cnt_q describe the bit currently on tx_line
    state_t       state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [7:0]   gap_q, gap_d;
    logic [7:0]   hdr_q, hdr_d;
    logic [3:0]   len_q, len_d;
    logic [127:0] pay_q, pay_d;
    logic [7:0]   crc_sh_q, crc_sh_d;
    logic         tx_q, tx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         last_bit;
    logic         crc_clear;
    logic         crc_en;
    logic [7:0]   crc_out;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .data_in(pay_q[127]),
        .crc_out(crc_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            hdr_q    <= '0;
            len_q    <= '0;
            pay_q    <= '0;
            crc_sh_q <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            hdr_q    <= hdr_d;
            len_q    <= len_d;
            pay_q    <= pay_d;
            crc_sh_q <= crc_sh_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        unique case (state_q)
            S_PREAMBLE:           last_bit = (cnt_q == 7'd15);
            S_SFD, S_HEADER, S_CRC: last_bit = (cnt_q == 7'd7);
            S_PAYLOAD:            last_bit = (cnt_q == {len_q, 3'b111});
            S_GAP:                last_bit = (gap_q == GAP_LAST);
            default:              last_bit = 1'b0;
        endcase
    end

    // Gap uses its own 8-bit counter since IFG_BITS can exceed the 7-bit bit counter range
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 7'd1;
        gap_d   = '0;
        hdr_d   = hdr_q;
        len_d   = len_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (start) begin
                state_d = S_PREAMBLE;
                hdr_d   = {dest_id, src_id, length};
                len_d   = length;
            end
        end else if (last_bit) begin
            cnt_d = '0;
            unique case (state_q)
                S_PREAMBLE: state_d = S_SFD;
                S_SFD:      state_d = S_HEADER;
                S_HEADER:   state_d = S_PAYLOAD;
                S_PAYLOAD:  state_d = S_CRC;
                S_CRC:      state_d = S_GAP;
                default:    state_d = S_IDLE;
            endcase
        end else if (state_q == S_GAP) begin
            cnt_d = '0;
            gap_d = gap_q + 8'd1;
        end
    end

    always_comb begin
        tx_d      = 1'b0;
        pay_d     = pay_q;
        crc_sh_d  = crc_sh_q;
        crc_en    = 1'b0;
        crc_clear = (state_q inside {S_IDLE, S_PREAMBLE, S_SFD, S_HEADER});
        if (state_q == S_IDLE && start) begin
            pay_d = payload << (7'd120 - {length, 3'b000});
        end
        unique case (state_d)
            S_PREAMBLE: tx_d = ~cnt_d[0];
            S_SFD:      tx_d = SFD[3'd7 - cnt_d[2:0]];
            S_HEADER:   tx_d = hdr_q[3'd7 - cnt_d[2:0]];
            S_PAYLOAD: begin
                tx_d   = pay_q[127];
                pay_d  = {pay_q[126:0], 1'b0};
                crc_en = 1'b1;
            end
            S_CRC: begin
                if (state_q == S_PAYLOAD) begin
                    tx_d     = crc_out[7];
                    crc_sh_d = {crc_out[6:0], 1'b0};
                end else begin
                    tx_d     = crc_sh_q[7];
                    crc_sh_d = {crc_sh_q[6:0], 1'b0};
                end
            end
            default:    tx_d = 1'b0;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_CRC) && (state_d == S_GAP);
    end

    assign tx_line = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
